// File: rtl/stv_fifo_pkg.sv
// stv_fifo_pkg: shared helpers for the flexible synchronous FIFO
package stv_fifo_pkg;
    function automatic int stv_cntw(input int depth);
        return $clog2(depth + 1);
    endfunction
    function automatic int stv_ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction
endpackage

// File: rtl/stv_fifo_outreg.sv
// stv_fifo_outreg: prefetch register holding the FIFO head for the registered read path
module stv_fifo_outreg
    import stv_fifo_pkg::*;
#(
    parameter type DTYPE = logic [7:0]
) (
    input  logic clk,
    input  logic arst,
    input  logic flush,
    input  logic wr,
    input  logic rd,
    input  DTYPE wdata,
    input  DTYPE mem_data,
    input  logic mem_avail,
    output logic valid,
    output DTYPE data,
    output logic mem_pop,
    output logic take_w
);
    logic valid_q, valid_d;
    DTYPE data_q, data_d;
    always_comb begin
        // a write bypasses memory whenever the head slot would otherwise be left empty
        take_w = wr && (!valid_q || (rd && !mem_avail));
        mem_pop = rd && mem_avail;
        valid_d = !flush && (take_w || mem_pop || (valid_q && !rd));
        data_d = mem_pop ? mem_data : (take_w ? wdata : data_q);
    end
    always_ff @(posedge clk or posedge arst) begin
        if (arst) valid_q <= 1'b0;
        else valid_q <= valid_d;
    end
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end
    assign valid = valid_q;
    assign data = data_q;
endmodule

// File: rtl/stv_sync_fifo_flex.sv
// stv_sync_fifo_flex: ready/valid FIFO with any depth, optional registered read, flush, thresholds and high-water mark
module stv_sync_fifo_flex
    import stv_fifo_pkg::*;
#(
    parameter type DTYPE = logic [7:0],
    parameter int DEPTH = 8,
    parameter bit FLOWTHROUGH = 0,
    parameter bit OUTREG = 0,
    localparam int CNTW = stv_cntw(DEPTH)
) (
    input  logic            clk,
    input  logic            arst,
    input  logic            rready,
    output logic            rvalid,
    output DTYPE            rdata,
    input  logic            wvalid,
    output logic            wready,
    input  DTYPE            wdata,
    input  logic            flush,
    input  logic [CNTW-1:0] afull_thresh,
    input  logic [CNTW-1:0] aempty_thresh,
    input  logic            hwm_clr,
    output logic            empty,
    output logic            full,
    output logic            almost_full,
    output logic            almost_empty,
    output logic [CNTW-1:0] count,
    output logic [CNTW-1:0] hwm
);
    // with the registered read path the head lives in the prefetch register, not in memory
    localparam int MD = OUTREG ? DEPTH - 1 : DEPTH;
    localparam int PW = MD > 1 ? $clog2(MD) : 1;
    DTYPE mem [MD];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNTW-1:0] count_q, count_d, hwm_q, hwm_d;
    logic wr, rd, mem_we, mem_re;
    assign empty = count_q == '0;
    assign full = count_q == CNTW'(DEPTH);
    assign almost_full = count_q >= afull_thresh;
    assign almost_empty = count_q <= aempty_thresh;
    assign count = count_q;
    assign hwm = hwm_q;
    assign wready = !flush && (!full || (FLOWTHROUGH && rready));
    assign wr = wvalid && wready;
    assign rd = rvalid && rready;
    if (OUTREG) begin : g_outreg
        logic pv, take_w;
        stv_fifo_outreg #(.DTYPE(DTYPE)) u_outreg (
            .clk(clk),
            .arst(arst),
            .flush(flush),
            .wr(wr),
            .rd(rd),
            .wdata(wdata),
            .mem_data(mem[rptr_q]),
            .mem_avail(count_q > CNTW'(1)),
            .valid(pv),
            .data(rdata),
            .mem_pop(mem_re),
            .take_w(take_w)
        );
        assign rvalid = pv && !flush;
        assign mem_we = wr && !take_w;
    end else begin : g_comb
        assign rvalid = !flush && (!empty || (FLOWTHROUGH && wvalid));
        assign rdata = (FLOWTHROUGH && empty) ? wdata : mem[rptr_q];
        assign mem_we = wr && !(FLOWTHROUGH && empty && rd);
        assign mem_re = rd && !(FLOWTHROUGH && empty);
    end
    always_comb begin
        wptr_d = flush ? '0 : (mem_we ? PW'(stv_ptr_inc(int'(wptr_q), MD)) : wptr_q);
        rptr_d = flush ? '0 : (mem_re ? PW'(stv_ptr_inc(int'(rptr_q), MD)) : rptr_q);
        count_d = flush ? '0 : count_q + CNTW'(wr) - CNTW'(rd);
        hwm_d = flush ? '0 : (hwm_clr ? count_d : (count_d > hwm_q ? count_d : hwm_q));
    end
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            count_q <= '0;
            hwm_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            count_q <= count_d;
            hwm_q <= hwm_d;
        end
    end
    always_ff @(posedge clk) begin
        if (mem_we) mem[wptr_q] <= wdata;
    end
    a_cfg: assert property (@(posedge clk) DEPTH >= 2 && !(FLOWTHROUGH && OUTREG));
    a_cnt: assert property (@(posedge clk) disable iff (arst) count_q <= CNTW'(DEPTH));
    a_ovf: assert property (@(posedge clk) disable iff (arst) (wr && full) |-> rd);
endmodule
